mdu_ctl: RTL and testbench
==========================

// Module: mdu_ctl
// PURPOSE
//  Sequencing controller for the HI/LO multiply/divide unit in the E stage.
//  - Accepts one MDU op per start and latches its operands.
//  - Runs a fixed-latency cycle counter per op class, then commits HI/LO.
//  - Raises stall_md so the D-stage stall controller holds any MDU instruction
//    while a mult/div is in flight.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for MULT/MULTU (legal range 1..15)
//  DIV_CYCLES   10  busy cycles for DIV/DIVU (legal range 1..15)
// PORTS
//  clk      in   1   pipeline clock, rising edge
//  rst_n    in   1   asynchronous, active-low reset
//  E_start  in   1   E-stage instr valid, operation given by E_op
//  E_op     in   4   0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 MFHI,8 MFLO
//  rs_val   in   32  forwarded rs operand (dividend / multiplicand / MT data)
//  rt_val   in   32  forwarded rt operand (divisor / multiplier)
//  D_isMD   in   1   D-stage instr is any MDU op (codes 1..8)
//  busy     out  1   mult/div in flight
//  stall_md out  1   D-stage stall request, ORed into the global stall
//  hi       out  32  HI register
//  lo       out  32  LO register
//  mf_data  out  32  E_op==7 ? hi : E_op==8 ? lo : 0 (combinational)
// BEHAVIOUR
//  Reset: busy=0, hi=0, lo=0, cnt=0, state=IDLE. Reset is asynchronous; an
//   in-flight op is discarded and never commits.
//  FSM states: IDLE, MUL, DIV.
//   IDLE -> MUL on E_start & op 1/2.
//   IDLE -> DIV on E_start & op 3/4.
//   MUL/DIV -> IDLE when cnt==1 at the clock edge.
//  Start (op 1..4, sampled at edge k, state IDLE):
//   - latch rs_val, rt_val and the signed/unsigned flag
//   - cnt <= N (N = MULT_CYCLES or DIV_CYCLES)
//   - busy=1 during cycles k+1..k+N; cnt decrements each edge
//   - HI/LO committed at edge k+N; busy=0 from cycle k+N+1
//  E_start with op 1..6 while not IDLE: ignored entirely. Unreachable in a
//   correct pipeline; the bench checks that it is ignored.
//  MTHI/MTLO (op 5/6): in IDLE only, hi/lo <= rs_val at the next edge; no busy.
//  MFHI/MFLO: mf_data is the current register value, with no HI/LO bypass.
//  Arithmetic, on latched operands:
//   - MULT  {hi,lo} = signed 32x32 -> 64
//   - MULTU {hi,lo} = unsigned 32x32 -> 64
//   - DIV   lo = quotient truncated toward zero, hi = remainder (sign of dividend)
//   - DIVU  unsigned quotient/remainder
//   - divisor 0: hi/lo unchanged, full DIV_CYCLES busy still taken
//   - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0
//  Stall: stall_md = D_isMD & (busy | (E_start & E_op in 1..4)).
//   - Also covers the start cycle, so the follower never sees stale HI/LO.
//   - Deasserts in the same cycle busy falls.
//  Non-MDU D-stage instructions never stall on busy.
// TESTING
//  1 Reset mid-op: MULT in flight at cycle 2, rst_n=0 -> busy=0, hi=lo=0
//    immediately (async); no later commit.
//  2 MULT rs=0xFFFFFFFE, rt=3 -> busy for 5 cycles, then hi=0xFFFFFFFF,
//    lo=0xFFFFFFFA. MULTU on the same operands -> hi=0x2, lo=0xFFFFFFFA.
//  3 DIV rs=-7 (0xFFFFFFF9), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10
//    busy cycles. DIVU 7/0 -> hi/lo unchanged, busy still 10 cycles.
//  4 MULT start with D_isMD=1 (MFLO follows) -> stall_md=1 at start and for
//    5 busy cycles, drops with busy; mf_data=new lo on the next E-stage MFLO.
//    With D_isMD=0 -> stall_md stays 0.
//  5 MTHI rs=0x1234 in IDLE -> hi=0x1234 next edge, busy stays 0.
//    MTLO issued during DIV busy -> ignored, lo takes the DIV result.
//  6 Back-to-back: DIV committing at edge k, MULT start at edge k+1 accepted
//    -> busy continuous except one low cycle; both results correct in sequence.

Source files
------------

// File: rtl/mdu_ctl.sv
// mdu_ctl: sequencing controller for the HI/LO multiply/divide unit (E stage).
// Accepts one mult/div per start, latches its operands, counts down a
// fixed per-class latency and then commits HI/LO. MTHI/MTLO write directly
// while idle. stall_md holds MDU instructions in D while a mult/div is
// starting or in flight.
//
// Ports
//   clk       in   1   pipeline clock, rising edge
//   rst_n     in   1   asynchronous active-low reset
//   E_start   in   1   E-stage instruction valid
//   E_op      in   4   0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 MFHI,8 MFLO
//   rs_val    in   32  rs operand (dividend / multiplicand / MT data)
//   rt_val    in   32  rt operand (divisor / multiplier)
//   D_isMD    in   1   D-stage instruction is an MDU op
//   busy      out  1   mult/div in flight
//   stall_md  out  1   D-stage stall request
//   hi, lo    out  32  HI/LO registers
//   mf_data   out  32  HI for MFHI, LO for MFLO, else 0
//
// state   | meaning
// IDLE    | no mult/div in flight; starts and MTHI/MTLO accepted
// MUL     | multiply latency countdown, commit {hi,lo} when cnt hits 1
// DIV     | divide latency countdown, commit quotient/remainder when cnt hits 1
module mdu_ctl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        E_start,
  input  logic [3:0]  E_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        D_isMD,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mf_data
);

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_t;

  state_t      state_q, state_nxt;
  logic [3:0]  cnt_q;
  logic [31:0] a_q, b_q;
  logic        sgn_q;

  logic is_mul_op, is_div_op, last_cycle;
  assign is_mul_op  = (E_op == 4'd1) || (E_op == 4'd2);
  assign is_div_op  = (E_op == 4'd3) || (E_op == 4'd4);
  assign last_cycle = (cnt_q == 4'd1);

  assign busy     = (state_q != ST_IDLE);
  assign stall_md = D_isMD & (busy | (E_start & (is_mul_op | is_div_op)));

  always_comb begin
    mf_data = 32'd0;
    if (E_op == 4'd7)      mf_data = hi;
    else if (E_op == 4'd8) mf_data = lo;
  end

  // Arithmetic works on the latched operands; its result is only sampled at
  // the terminal count, so these paths are multicycle by construction.
  logic [63:0] prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;

  always_comb begin
    if (sgn_q)
      prod = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    else
      prod = {32'd0, a_q} * {32'd0, b_q};
  end

  // Signed divide via magnitudes: 0x80000000 / -1 falls out as 0x80000000
  // with remainder 0 without a special case.
  always_comb begin
    a_neg = sgn_q & a_q[31];
    b_neg = sgn_q & b_q[31];
    a_mag = a_neg ? (32'd0 - a_q) : a_q;
    b_mag = b_neg ? (32'd0 - b_q) : b_q;
    q_mag = 32'd0;
    r_mag = 32'd0;
    if (b_mag != 32'd0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    quo = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: begin
        if (E_start && is_mul_op)      state_nxt = ST_MUL;
        else if (E_start && is_div_op) state_nxt = ST_DIV;
      end
      ST_MUL, ST_DIV: if (last_cycle) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      sgn_q <= 1'b0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (E_start) begin
            if (is_mul_op || is_div_op) begin
              a_q   <= rs_val;
              b_q   <= rt_val;
              sgn_q <= (E_op == 4'd1) || (E_op == 4'd3);
              cnt_q <= is_mul_op ? MULT_N : DIV_N;
            end else if (E_op == 4'd5) begin
              hi <= rs_val;
            end else if (E_op == 4'd6) begin
              lo <= rs_val;
            end
          end
        end
        ST_MUL: begin
          cnt_q <= cnt_q - 4'd1;
          if (last_cycle) begin
            hi <= prod[63:32];
            lo <= prod[31:0];
          end
        end
        ST_DIV: begin
          cnt_q <= cnt_q - 4'd1;
          // Divide by zero still takes the full latency but leaves HI/LO alone.
          if (last_cycle && (b_q != 32'd0)) begin
            hi <= rem;
            lo <= quo;
          end
        end
        default: cnt_q <= 4'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctl.sv
module tb_mdu_ctl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        E_start = 1'b0;
  logic [3:0]  E_op = 4'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        D_isMD = 1'b0;
  logic        busy, stall_md;
  logic [31:0] hi, lo, mf_data;

  int n_chk = 0;
  int n_err = 0;

  mdu_ctl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .rst_n(rst_n), .E_start(E_start), .E_op(E_op),
    .rs_val(rs_val), .rt_val(rt_val), .D_isMD(D_isMD),
    .busy(busy), .stall_md(stall_md), .hi(hi), .lo(lo), .mf_data(mf_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural model: HI/LO, cycles of latency remaining, pending result.
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_phi = 32'd0, m_plo = 32'd0;
  logic        m_pupd = 1'b0;
  int          m_left = 0;

  function automatic void mdu_result(input logic [3:0] op, input logic [31:0] a,
                                     input logic [31:0] b, output logic upd,
                                     output logic [31:0] h, output logic [31:0] l);
    longint sa, sb, q, r;
    logic [63:0] p;
    upd = 1'b1; h = 32'd0; l = 32'd0;
    if (op == 4'd1 || op == 4'd3) begin
      sa = longint'($signed(a)); sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a}); sb = longint'({32'd0, b});
    end
    if (op == 4'd1 || op == 4'd2) begin
      if (op == 4'd1) p = 64'(sa * sb);
      else            p = {32'd0, a} * {32'd0, b};
      h = p[63:32]; l = p[31:0];
    end else if (b == 32'd0) begin
      upd = 1'b0;
    end else begin
      q = sa / sb; r = sa % sb;
      h = r[31:0]; l = q[31:0];
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi = 32'd0; m_lo = 32'd0; m_left = 0; m_pupd = 1'b0;
    end else begin
      int was_left;
      was_left = m_left;
      if (m_left > 0) begin
        m_left = m_left - 1;
        if (m_left == 0 && m_pupd) begin
          m_hi = m_phi; m_lo = m_plo;
        end
      end
      if (was_left == 0 && E_start) begin
        if (E_op >= 4'd1 && E_op <= 4'd4) begin
          mdu_result(E_op, rs_val, rt_val, m_pupd, m_phi, m_plo);
          m_left = (E_op <= 4'd2) ? MULT_N : DIV_N;
        end else if (E_op == 4'd5) begin
          m_hi = rs_val;
        end else if (E_op == 4'd6) begin
          m_lo = rs_val;
        end
      end
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    logic exp_busy, exp_stall;
    logic [31:0] exp_mf;
    exp_busy  = (m_left > 0);
    exp_stall = D_isMD & (exp_busy | (E_start & (E_op >= 4'd1) & (E_op <= 4'd4)));
    exp_mf    = (E_op == 4'd7) ? m_hi : (E_op == 4'd8) ? m_lo : 32'd0;
    chk("busy", {31'd0, busy}, {31'd0, exp_busy});
    chk("stall_md", {31'd0, stall_md}, {31'd0, exp_stall});
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("mf_data", mf_data, exp_mf);
  end

  logic [31:0] pre_mf;
  int stall_cnt = 0;

  // Drive one cycle's inputs just after a rising edge, return just after the next.
  task automatic step(input logic st, input logic [3:0] op, input logic [31:0] rs,
                      input logic [31:0] rt, input logic dis);
    E_start = st; E_op = op; rs_val = rs; rt_val = rt; D_isMD = dis;
    #2;
    pre_mf = mf_data;
    if (stall_md === 1'b1) stall_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input logic dis, output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      step(1'b0, 4'd0, 32'd0, 32'd0, dis);
      n++;
    end
  endtask

  int n;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    rst_n = 1'b1;

    // MTHI / MTLO in idle
    step(1'b1, 4'd5, 32'h1234, 32'd0, 1'b0);
    chk("mthi_hi", hi, 32'h1234);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    step(1'b1, 4'd6, 32'h5555, 32'd0, 1'b0);
    chk("mtlo_lo", lo, 32'h5555);

    // Async reset with a MULT in flight
    step(1'b1, 4'd1, 32'd3, 32'd4, 1'b0);
    step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    chk("rst_nocommit_lo", lo, 32'd0);

    // MULT / MULTU
    step(1'b1, 4'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
    wait_idle(1'b0, n);
    chk("mult_cycles", n, MULT_N);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);
    step(1'b1, 4'd2, 32'hFFFFFFFE, 32'd3, 1'b0);
    wait_idle(1'b0, n);
    chk("multu_hi", hi, 32'h2);
    chk("multu_lo", lo, 32'hFFFFFFFA);

    // DIV / DIVU / divide by zero / overflow case
    step(1'b1, 4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    wait_idle(1'b0, n);
    chk("div_cycles", n, DIV_N);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
    step(1'b1, 4'd4, 32'd7, 32'd0, 1'b0);
    wait_idle(1'b0, n);
    chk("div0_cycles", n, DIV_N);
    chk("div0_lo", lo, 32'hFFFFFFFD);
    chk("div0_hi", hi, 32'hFFFFFFFF);
    step(1'b1, 4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    wait_idle(1'b0, n);
    chk("divovf_lo", lo, 32'h80000000);
    chk("divovf_hi", hi, 32'd0);

    // Stall with an MDU follower, then MFLO
    stall_cnt = 0;
    step(1'b1, 4'd1, 32'd6, 32'd7, 1'b1);
    wait_idle(1'b1, n);
    chk("stall_cycles", stall_cnt, MULT_N + 1);
    step(1'b1, 4'd8, 32'd0, 32'd0, 1'b0);
    chk("mflo_data", pre_mf, 32'd42);
    stall_cnt = 0;
    step(1'b1, 4'd1, 32'd6, 32'd8, 1'b0);
    wait_idle(1'b0, n);
    chk("nostall_cycles", stall_cnt, 0);
    step(1'b1, 4'd7, 32'd0, 32'd0, 1'b0);
    chk("mfhi_data", pre_mf, 32'd0);

    // MTLO and MULT issued during DIV busy are ignored
    step(1'b1, 4'd3, 32'd100, 32'd7, 1'b0);
    step(1'b1, 4'd6, 32'hDEAD, 32'd0, 1'b0);
    step(1'b1, 4'd1, 32'd9, 32'd9, 1'b0);
    wait_idle(1'b0, n);
    chk("ign_cycles", n, DIV_N - 2);
    chk("ign_lo", lo, 32'd14);
    chk("ign_hi", hi, 32'd2);

    // Back-to-back: MULT accepted the edge after the DIV commit
    step(1'b1, 4'd3, 32'd20, 32'd3, 1'b0);
    repeat (DIV_N - 1) step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    chk("b2b_busy_last", {31'd0, busy}, 32'd1);
    step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    chk("b2b_gap_busy", {31'd0, busy}, 32'd0);
    chk("b2b_div_lo", lo, 32'd6);
    chk("b2b_div_hi", hi, 32'd2);
    step(1'b1, 4'd1, 32'd5, 32'hFFFFFFFE, 1'b0);
    chk("b2b_mul_busy", {31'd0, busy}, 32'd1);
    wait_idle(1'b0, n);
    chk("b2b_mul_cycles", n, MULT_N);
    chk("b2b_mul_hi", hi, 32'hFFFFFFFF);
    chk("b2b_mul_lo", lo, 32'hFFFFFFF6);

    step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
